// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// 32 lines of 32-byte blocks; tag = addr[31:10], index = addr[9:5], word = addr[4:2].
// Ports:
//   clk_i, rst_i (async, active-low)
//   cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i : MEM-stage access, held while stalled
//   cpu_data_o, stall_o                            : load data, pipeline freeze
//   mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, mem_data_i, mem_ack_i : block memory port
module dcache_controller (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_write_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [1:0] {StIdle, StWriteback, StRefill} state_e;

    state_e state_q, state_d;
    logic [31:0]  valid_q, valid_d;
    logic [31:0]  dirty_q, dirty_d;
    logic [21:0]  tag_q [32];
    logic [255:0] data_q [32];

    logic [21:0]  req_tag;
    logic [4:0]   req_idx;
    logic [7:0]   bit_off;
    logic [21:0]  line_tag;
    logic [255:0] line_data;
    logic         hit;

    logic         line_we, tag_we;
    logic [255:0] line_wdata;
    logic         stall;
    logic         mem_en, mem_wr;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [31:0]  rdata;

    // Byte offset within the word is irrelevant to a word-wide cache.
    logic unused_byte_off;
    assign unused_byte_off = ^cpu_addr_i[1:0];

    assign req_tag   = cpu_addr_i[31:10];
    assign req_idx   = cpu_addr_i[9:5];
    assign bit_off   = {cpu_addr_i[4:2], 5'b0};
    assign line_tag  = tag_q[req_idx];
    assign line_data = data_q[req_idx];
    assign hit       = cpu_req_i & valid_q[req_idx] & (line_tag == req_tag);

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        line_we    = 1'b0;
        tag_we     = 1'b0;
        line_wdata = line_data;
        stall      = 1'b0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 256'h0;
        rdata      = 32'h0;

        unique case (state_q)
            StIdle: begin
                if (cpu_req_i) begin
                    if (hit) begin
                        if (cpu_write_i) begin
                            line_wdata[bit_off +: 32] = cpu_data_i;
                            line_we                   = 1'b1;
                            dirty_d[req_idx]          = 1'b1;
                        end else begin
                            rdata = line_data[bit_off +: 32];
                        end
                    end else begin
                        stall   = 1'b1;
                        state_d = (valid_q[req_idx] & dirty_q[req_idx]) ? StWriteback : StRefill;
                    end
                end
            end
            StWriteback: begin
                stall     = 1'b1;
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {line_tag, req_idx, 5'b0};
                mem_wdata = line_data;
                if (mem_ack_i) begin
                    state_d = StRefill;
                end
            end
            StRefill: begin
                stall    = 1'b1;
                mem_en   = 1'b1;
                mem_addr = {req_tag, req_idx, 5'b0};
                if (mem_ack_i) begin
                    line_we          = 1'b1;
                    tag_we           = 1'b1;
                    line_wdata       = mem_data_i;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    state_d          = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset is also applied combinationally so outputs are quiet while it is held.
    assign stall_o      = rst_i & stall;
    assign cpu_data_o   = rst_i ? rdata : 32'h0;
    assign mem_enable_o = rst_i & mem_en;
    assign mem_write_o  = rst_i & mem_wr;
    assign mem_addr_o   = rst_i ? mem_addr : 32'h0;
    assign mem_data_o   = rst_i ? mem_wdata : 256'h0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            valid_q <= 32'h0;
            dirty_q <= 32'h0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays need no reset; valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            data_q[req_idx] <= line_wdata;
        end
        if (tag_we) begin
            tag_q[req_idx] <= req_tag;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_write_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         stall_o, mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;

    int n_checks = 0;
    int n_errors = 0;

    dcache_controller u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_write_i  (cpu_write_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_data_o   (cpu_data_o),
        .stall_o      (stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cpu(input logic req, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata);
        cpu_req_i   = req;
        cpu_write_i = wr;
        cpu_addr_i  = addr;
        cpu_data_i  = wdata;
    endtask

    logic [255:0] blk_a, blk_a_dirty, blk_b;

    initial begin
        for (int k = 0; k < 8; k++) begin
            blk_a[32*k +: 32] = 32'hA000_0000 + k;
            blk_b[32*k +: 32] = 32'hB000_0000 + k;
        end
        blk_a[63:32]  = 32'hDEADBEEF;
        blk_b[31:0]   = 32'hCAFEF00D;
        blk_a_dirty   = blk_a;
        blk_a_dirty[95:64] = 32'h12345678;

        rst_i      = 1'b0;
        mem_ack_i  = 1'b0;
        mem_data_i = 256'h0;
        cpu(1'b1, 1'b0, 32'h0000_0404, 32'h0);

        // Outputs held quiet during reset even with a request pending.
        @(negedge clk_i);
        check("rst_stall", {255'h0, stall_o}, 256'h0);
        check("rst_men",   {255'h0, mem_enable_o}, 256'h0);
        check("rst_mwr",   {255'h0, mem_write_o}, 256'h0);
        check("rst_rdata", {224'h0, cpu_data_o}, 256'h0);
        check("rst_maddr", {224'h0, mem_addr_o}, 256'h0);

        // Cold miss on load 0x404.
        next_cycle();
        rst_i = 1'b1;
        #1;
        check("miss_stall", {255'h0, stall_o}, 256'h1);
        check("miss_men_idle", {255'h0, mem_enable_o}, 256'h0);
        next_cycle();
        @(negedge clk_i);
        check("refill_men",   {255'h0, mem_enable_o}, 256'h1);
        check("refill_mwr",   {255'h0, mem_write_o}, 256'h0);
        check("refill_addr",  {224'h0, mem_addr_o}, {224'h0, 32'h0000_0400});
        check("refill_stall", {255'h0, stall_o}, 256'h1);
        next_cycle();
        mem_ack_i  = 1'b1;
        mem_data_i = blk_a;
        @(negedge clk_i);
        check("refill_ack_stall", {255'h0, stall_o}, 256'h1);
        next_cycle();
        mem_ack_i = 1'b0;
        mem_data_i = 256'h0;
        @(negedge clk_i);
        check("after_refill_stall", {255'h0, stall_o}, 256'h0);
        check("after_refill_data",  {224'h0, cpu_data_o}, {224'h0, 32'hDEADBEEF});

        // Repeat load is a zero-latency hit.
        next_cycle();
        @(negedge clk_i);
        check("hit_stall", {255'h0, stall_o}, 256'h0);
        check("hit_men",   {255'h0, mem_enable_o}, 256'h0);
        check("hit_data",  {224'h0, cpu_data_o}, {224'h0, 32'hDEADBEEF});
        next_cycle();
        cpu(1'b1, 1'b0, 32'h0000_0400, 32'h0);
        @(negedge clk_i);
        check("hit_word0", {224'h0, cpu_data_o}, {224'h0, 32'hA000_0000});

        // Store hit, then read back.
        next_cycle();
        cpu(1'b1, 1'b1, 32'h0000_0408, 32'h12345678);
        @(negedge clk_i);
        check("store_stall", {255'h0, stall_o}, 256'h0);
        next_cycle();
        cpu(1'b1, 1'b0, 32'h0000_0408, 32'h0);
        @(negedge clk_i);
        check("store_read_stall", {255'h0, stall_o}, 256'h0);
        check("store_read_data", {224'h0, cpu_data_o}, {224'h0, 32'h12345678});

        // Conflict miss with dirty victim: writeback first, ack held off 10 cycles.
        next_cycle();
        cpu(1'b1, 1'b0, 32'h0000_0800, 32'h0);
        @(negedge clk_i);
        check("dirty_miss_stall", {255'h0, stall_o}, 256'h1);
        next_cycle();
        @(negedge clk_i);
        check("wb_men",  {255'h0, mem_enable_o}, 256'h1);
        check("wb_mwr",  {255'h0, mem_write_o}, 256'h1);
        check("wb_addr", {224'h0, mem_addr_o}, {224'h0, 32'h0000_0400});
        check("wb_data", mem_data_o, blk_a_dirty);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            @(negedge clk_i);
            check("wb_wait", {mem_data_o[223:0], stall_o, mem_enable_o, mem_write_o, mem_addr_o[28:0]},
                  {blk_a_dirty[223:0], 3'b111, 29'h0000_0400});
        end
        next_cycle();
        mem_ack_i  = 1'b1;
        mem_data_i = blk_b;  // must not be written on a writeback ack
        next_cycle();
        mem_ack_i  = 1'b0;
        mem_data_i = 256'h0;
        @(negedge clk_i);
        check("wb2refill_mwr",  {255'h0, mem_write_o}, 256'h0);
        check("wb2refill_addr", {224'h0, mem_addr_o}, {224'h0, 32'h0000_0800});
        check("wb2refill_stall", {255'h0, stall_o}, 256'h1);
        next_cycle();
        mem_ack_i  = 1'b1;
        mem_data_i = blk_b;
        next_cycle();
        mem_ack_i  = 1'b0;
        mem_data_i = 256'h0;
        @(negedge clk_i);
        check("refill2_stall", {255'h0, stall_o}, 256'h0);
        check("refill2_data",  {224'h0, cpu_data_o}, {224'h0, 32'hCAFEF00D});

        // Idle ack is ignored; no request means no stall.
        next_cycle();
        cpu(1'b0, 1'b0, 32'h0000_0800, 32'h0);
        mem_ack_i  = 1'b1;
        mem_data_i = {8{32'h5555_5555}};
        @(negedge clk_i);
        check("noreq_stall", {255'h0, stall_o}, 256'h0);
        check("noreq_men",   {255'h0, mem_enable_o}, 256'h0);
        next_cycle();
        mem_ack_i = 1'b0;
        cpu(1'b1, 1'b0, 32'h0000_0800, 32'h0);
        @(negedge clk_i);
        check("idle_ack_ignored", {224'h0, cpu_data_o}, {224'h0, 32'hCAFEF00D});

        // Refilled line is clean: its eviction goes straight to refill.
        next_cycle();
        cpu(1'b1, 1'b0, 32'h0000_0404, 32'h0);
        next_cycle();
        @(negedge clk_i);
        check("clean_evict_mwr",  {255'h0, mem_write_o}, 256'h0);
        check("clean_evict_addr", {224'h0, mem_addr_o}, {224'h0, 32'h0000_0400});

        // Reset mid-refill drops the request at once.
        #1;
        rst_i = 1'b0;
        #1;
        check("midrst_men",   {255'h0, mem_enable_o}, 256'h0);
        check("midrst_stall", {255'h0, stall_o}, 256'h0);
        next_cycle();
        mem_ack_i  = 1'b1;
        mem_data_i = blk_a;
        next_cycle();
        mem_ack_i = 1'b0;
        rst_i     = 1'b1;
        #1;
        check("post_rst_miss", {255'h0, stall_o}, 256'h1);
        cpu(1'b1, 1'b0, 32'h0000_0800, 32'h0);
        #1;
        check("post_rst_miss2", {255'h0, stall_o}, 256'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 Geometry is fixed (no parameters): direct-mapped, 32 lines, 32-byte (256-bit) blocks, write-back, write-allocate.
REQ-002 Address split SHALL be tag = addr[31:10] (22 b), index = addr[9:5], word select = addr[4:2]; addr[1:0] ignored.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 cpu_req_i  input  1  MEM-stage valid load/store this cycle.
REQ-006 cpu_write_i  input  1  1 = store, 0 = load.
REQ-007 cpu_addr_i  input  32  byte address (MEM-stage ALU result).
REQ-008 cpu_data_i  input  32  store data (MEM-stage forwarded rs2 data).
REQ-009 cpu_data_o  output  32  load data, valid while cpu_req_i=1 and stall_o=0.
REQ-010 stall_o  output  1  freezes PC and all pipeline buffers while high.
REQ-011 mem_enable_o  output  1  memory request.
REQ-012 mem_write_o  output  1  1 = block write-back, 0 = block fetch.
REQ-013 mem_addr_o  output  32  block-aligned address, [4:0] = 0.
REQ-014 mem_data_o  output  256  write-back block.
REQ-015 mem_data_i  input  256  fetched block.
REQ-016 mem_ack_i  input  1  one-cycle completion pulse.

Function
REQ-017 Per line storage: valid bit, dirty bit, 22-bit tag, 256-bit data.
REQ-018 Hit = cpu_req_i & valid[index] & (tag[index] == addr tag); evaluated combinationally only in state IDLE.
REQ-019 Load hit: cpu_data_o = selected word same cycle; stall_o = 0; zero added latency.
REQ-020 Store hit: selected word replaced by cpu_data_i at the rising edge; dirty[index] set; stall_o = 0.
REQ-021 Miss (cpu_req_i & ~hit in IDLE): stall_o = 1 combinationally in that cycle.
REQ-022 FSM states: IDLE, WRITEBACK, REFILL.
REQ-023 IDLE -> WRITEBACK on miss with valid & dirty victim; IDLE -> REFILL on miss with clean or invalid victim; otherwise stay.
REQ-024 WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o = victim block; on mem_ack_i -> REFILL.
REQ-025 REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 5'b0}; on mem_ack_i, line gets data=mem_data_i, tag=cpu tag, valid=1, dirty=0; -> IDLE.
REQ-026 stall_o = 1 in every WRITEBACK and REFILL cycle, including the ack cycle.
REQ-027 First IDLE cycle after refill re-evaluates the held access as a hit: stall_o = 0, load data returned or store merged (dirty set).
REQ-028 Clean-miss cost: 1 detect cycle + N memory-wait cycles; N = REFILL cycles up to and including ack.
REQ-029 mem_addr_o, mem_write_o, mem_data_o stable while mem_enable_o = 1; mem_enable_o = 0 in IDLE.
REQ-030 mem_ack_i in IDLE ignored; ack in WRITEBACK never writes the data array.
REQ-031 cpu inputs are held by the stalled pipeline; the block does not latch them.
REQ-032 cpu_req_i = 0: stall_o = 0; no state change.

Reset
REQ-033 rst_i low asynchronously forces state IDLE and clears all valid and dirty bits; tags/data need no reset.
REQ-034 During reset: mem_enable_o=0, mem_write_o=0, stall_o=0, cpu_data_o=0, mem_addr_o=0.
REQ-035 Reset mid-transfer abandons it: mem_enable_o drops immediately; a later ack is ignored.

Verification
REQ-036 After reset, load 0x0000_0404 -> stall_o=1; REFILL addr 0x0000_0400; ack with word1=0xDEADBEEF -> next cycle stall_o=0, cpu_data_o=0xDEADBEEF.
REQ-037 Repeat load 0x0000_0404 -> stall_o=0 same cycle; mem_enable_o stays 0.
REQ-038 Store 0x12345678 to 0x0000_0408 (hit) -> no stall; load 0x0000_0408 -> 0x12345678; dirty[0]=1.
REQ-039 Load 0x0000_0800 (same index 0, dirty victim) -> WRITEBACK addr 0x0000_0400, mem_data_o word2=0x12345678; ack -> REFILL addr 0x0000_0800; ack -> data returned.
REQ-040 Ack delayed 10 cycles -> stall_o high and mem outputs stable all 10 cycles.
REQ-041 rst_i low during REFILL -> mem_enable_o=0 at once; after release, load same address misses again.
